// File: rtl/rf_bus_slave.sv
// ---------------------------------------------------------------------------
// rf_bus_slave
//
// Simple bus slave that fronts a 23-entry register file. A request is taken
// from the bus only while the FSM is idle; writes are turned into a one-cycle
// one-hot write enable, reads go through an external registered read mux, and
// requests to unmapped addresses are answered immediately with an error and
// counted in a saturating error counter.
//
// Register map (register index in brackets):
//   0x0100-0x0109 [0-9], 0x0110-0x0119 [10-19], 0x0120-0x0122 [20-22]
//
// Ports:
//   clk       in   system clock, all state changes on the rising edge
//   reset_n   in   synchronous active-low reset
//   s_sel     in   bus request strobe
//   s_wr      in   request type, 1 = write, 0 = read
//   s_addr    in   [15:0] request address
//   s_din     in   [DW-1:0] write data
//   s_dout    out  [DW-1:0] read data, held until the next read/error reply
//   s_ready   out  one-cycle transaction-complete pulse
//   s_err     out  invalid-address flag, meaningful while s_ready is high
//   rf_wen    out  [22:0] one-hot register write enables
//   rf_wdata  out  [DW-1:0] register write data
//   rf_raddr  out  [15:0] address to the registered read-mux stage
//   rf_rdata  in   [DW-1:0] read-mux output, valid one edge after rf_raddr
//   err_cnt   out  [7:0] saturating count of invalid-address transactions
// ---------------------------------------------------------------------------
module rf_bus_slave #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          s_sel,
  input  logic          s_wr,
  input  logic [15:0]   s_addr,
  input  logic [DW-1:0] s_din,
  output logic [DW-1:0] s_dout,
  output logic          s_ready,
  output logic          s_err,
  output logic [22:0]   rf_wen,
  output logic [DW-1:0] rf_wdata,
  output logic [15:0]   rf_raddr,
  input  logic [DW-1:0] rf_rdata,
  output logic [7:0]    err_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD0,
    RD1,
    RESP
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic          addr_valid;
  logic [4:0]    reg_idx;
  logic [22:0]   wen_onehot;

  logic [DW-1:0] dout_nxt;
  logic          ready_nxt;
  logic          err_nxt;
  logic [22:0]   wen_nxt;
  logic [DW-1:0] wdata_nxt;
  logic [15:0]   raddr_nxt;
  logic [7:0]    err_cnt_nxt;

  // Address decode: the map has three banks of 16 slots at 0x0100, 0x0110 and
  // 0x0120, each only partly populated, so the low nibble is range-checked
  // per bank and the bank base index is added to it.
  always_comb begin
    addr_valid = 1'b0;
    reg_idx    = 5'd0;
    if (s_addr[15:8] == 8'h01) begin
      case (s_addr[7:4])
        4'h0: begin
          if (s_addr[3:0] <= 4'd9) begin
            addr_valid = 1'b1;
            reg_idx    = {1'b0, s_addr[3:0]};
          end
        end
        4'h1: begin
          if (s_addr[3:0] <= 4'd9) begin
            addr_valid = 1'b1;
            reg_idx    = 5'd10 + {1'b0, s_addr[3:0]};
          end
        end
        4'h2: begin
          if (s_addr[3:0] <= 4'd2) begin
            addr_valid = 1'b1;
            reg_idx    = 5'd20 + {1'b0, s_addr[3:0]};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign wen_onehot = 23'd1 << reg_idx;

  // Next-state and next-output logic. The pulse-type outputs (s_ready, s_err,
  // rf_wen) default to low so each is high for exactly one cycle; the data
  // outputs and the error counter default to holding their value.
  always_comb begin
    state_nxt   = state;
    dout_nxt    = s_dout;
    ready_nxt   = 1'b0;
    err_nxt     = 1'b0;
    wen_nxt     = '0;
    wdata_nxt   = rf_wdata;
    raddr_nxt   = rf_raddr;
    err_cnt_nxt = err_cnt;

    case (state)
      IDLE: begin
        if (s_sel) begin
          if (!addr_valid) begin
            // Errors answer on the accepting edge and never touch the
            // register file or the read address.
            ready_nxt   = 1'b1;
            err_nxt     = 1'b1;
            dout_nxt    = '0;
            err_cnt_nxt = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
            state_nxt   = RESP;
          end else if (s_wr) begin
            wen_nxt   = wen_onehot;
            wdata_nxt = s_din;
            state_nxt = WR;
          end else begin
            raddr_nxt = s_addr;
            state_nxt = RD0;
          end
        end
      end
      WR: begin
        ready_nxt = 1'b1;
        state_nxt = RESP;
      end
      RD0: begin
        // Gives the external read mux the edge it needs to register rf_raddr.
        state_nxt = RD1;
      end
      RD1: begin
        dout_nxt  = rf_rdata;
        ready_nxt = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      s_dout   <= '0;
      s_ready  <= 1'b0;
      s_err    <= 1'b0;
      rf_wen   <= '0;
      rf_wdata <= '0;
      rf_raddr <= 16'h0000;
      err_cnt  <= 8'd0;
    end else begin
      state    <= state_nxt;
      s_dout   <= dout_nxt;
      s_ready  <= ready_nxt;
      s_err    <= err_nxt;
      rf_wen   <= wen_nxt;
      rf_wdata <= wdata_nxt;
      rf_raddr <= raddr_nxt;
      err_cnt  <= err_cnt_nxt;
    end
  end

endmodule
